btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels.
REQ-002 Parameter ACTIVE_LOW, default 1: when 1, a raw input level of 0 means pressed (UP2 push-buttons).
REQ-003 Parameter DB_CYCLES, default 500000: consecutive stable cycles required to accept a level change; legal range 2 or more.
REQ-004 Parameter REPEAT_DELAY, default 25000000: hold cycles after the press pulse before the first auto-repeat pulse; legal range 2 or more.
REQ-005 Parameter REPEAT_PERIOD, default 5000000: cycles between successive auto-repeat pulses; legal range 2 or more.
REQ-006 Parameter REPEAT_MASK, default 4'b1100: per-channel auto-repeat enable (channels 2 and 3, add-sec and add-min).
REQ-007 MCLK  input  1  single clock for all state.
REQ-008 RST  input  1  reset, synchronous to MCLK, active-high.
REQ-009 BT  input  N_BTN  raw asynchronous button levels.
REQ-010 BT_LEVEL  output  N_BTN  debounced state, 1 = pressed, independent of ACTIVE_LOW.
REQ-011 BT_PRESS  output  N_BTN  one-cycle pulse on each accepted press.
REQ-012 BT_RELEASE  output  N_BTN  one-cycle pulse on each accepted release.
REQ-013 BT_REPEAT  output  N_BTN  one-cycle pulse on press, then on each auto-repeat while held.

Function
REQ-014 Each BT bit SHALL pass through a 2-flop synchronizer; after inversion when ACTIVE_LOW=1, the synchronizer output is called s.
REQ-015 Each channel SHALL have a stability counter, sized to hold DB_CYCLES-1:
- cleared whenever s equals BT_LEVEL;
- incremented when s differs from BT_LEVEL;
- when s differs and the counter equals DB_CYCLES-1, BT_LEVEL toggles and the counter clears.
REQ-016 Latency SHALL be exactly DB_CYCLES+2 edges, counted from the first edge that samples a new stable raw level to the edge where BT_LEVEL changes.
REQ-017 A raw glitch shorter than DB_CYCLES cycles (after synchronization) SHALL leave BT_LEVEL unchanged and produce no pulses.
REQ-018 BT_PRESS and BT_RELEASE SHALL be registered and assert in the same cycle BT_LEVEL goes 0->1 or 1->0 respectively, for one cycle only.
REQ-019 The repeat state machine SHALL be per channel, with states IDLE, DELAY and RPT, and a hold counter sized for max(REPEAT_DELAY, REPEAT_PERIOD):
- IDLE -> DELAY on accepted press; BT_REPEAT pulses in the same cycle as BT_PRESS; the hold counter clears.
- In DELAY, the hold counter increments each cycle; when it reaches REPEAT_DELAY-1, BT_REPEAT pulses, the counter clears and the state goes to RPT.
- In RPT, when the counter reaches REPEAT_PERIOD-1, BT_REPEAT pulses and the counter clears; the state stays in RPT.
- From DELAY or RPT, an accepted release goes to IDLE with no BT_REPEAT pulse that cycle, even if the counter reached its terminal value.
REQ-020 For channels with REPEAT_MASK bit 0, BT_REPEAT SHALL equal BT_PRESS and the FSM SHALL stay in IDLE.
REQ-021 Channels SHALL be fully independent; simultaneous presses on several channels SHALL produce simultaneous pulses.
REQ-022 Total cycles SHALL be counted: first repeat pulse is REPEAT_DELAY cycles after the press pulse, subsequent pulses every REPEAT_PERIOD cycles.
REQ-023 No output SHALL depend combinationally on BT.

Reset
REQ-024 While RST=1 at an edge, these SHALL be forced:
- synchronizer flops to the not-pressed raw level;
- stability and hold counters to 0;
- FSMs to IDLE;
- BT_LEVEL, BT_PRESS, BT_RELEASE and BT_REPEAT to 0.
REQ-025 Reset mid-debounce or mid-hold SHALL discard all progress and emit no pulse.
REQ-026 A button held through RST deassertion SHALL be treated as a new press: BT_PRESS is asserted DB_CYCLES+2 edges after the first post-reset edge.

Verification
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1.
REQ-027 Clean press, BT[0] 1->0 held 30 cycles, then released -> exactly one BT_PRESS[0] 6 edges after the press edge; exactly one BT_RELEASE[0] 6 edges after release; BT_REPEAT[0]=BT_PRESS[0]; BT_LEVEL[0] high in between.
REQ-028 Glitch: BT[1]=0 for 3 cycles, then 1 -> BT_LEVEL[1] stays 0; no pulses on channel 1.
REQ-029 Auto-repeat: BT[2] held 0 for 40 cycles -> BT_REPEAT[2] pulses at press cycle P, then P+10, P+13, P+16, and so on until release; no pulse at or after the release cycle.
REQ-030 Bouncy edge: BT[3] toggles 0/1/0/1/0 at 1-cycle intervals, then holds 0 -> exactly one BT_PRESS[3], 6 edges after the final transition.
REQ-031 Reset mid-hold: BT[2] held and RST pulsed for 1 cycle at P+5 -> all outputs 0 the next cycle; a new BT_PRESS[2] arrives 6 edges after RST deasserts, and the repeat timing restarts from it.
REQ-032 Simultaneous: BT[0] and BT[3] pressed on the same edge -> BT_PRESS[0] and BT_PRESS[3] are asserted in the same cycle.

Source files
------------

// File: rtl/btn_conditioner.sv
// Button conditioner: per-channel synchronizer, debouncer, edge pulses and auto-repeat.
// Every channel is independent and all state is clocked by MCLK with synchronous reset.

module btn_channel #(
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       level,
  output logic       press,
  output logic       rls,
  output logic       rpt,
  output logic [1:0] state
);

  localparam int CW       = $clog2(DB_CYCLES);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = $clog2(HOLD_MAX);

  localparam logic          RAW_IDLE    = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_e;

  logic          sync1_q;
  logic          sync2_q;
  logic          s;
  logic [CW-1:0] stab_q;
  logic          accept;
  logic          press_evt;
  logic          release_evt;

  rpt_state_e    state_q;
  rpt_state_e    state_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          rpt_d;

  // s is the synchronized level in "1 = pressed" polarity.
  assign s           = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign accept      = (s != level) && (stab_q == DB_LAST);
  assign press_evt   = accept & ~level;
  assign release_evt = accept & level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
      stab_q  <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rls     <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press   <= press_evt;
      rls     <= release_evt;
      if ((s == level) || accept) begin
        stab_q <= '0;
      end else begin
        stab_q <= stab_q + 1'b1;
      end
      if (accept) begin
        level <= ~level;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rpt     <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rpt     <= rpt_d;
    end
  end

  // A release always wins over a terminal hold count, so no repeat fires on release.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rpt_d   = 1'b0;
    if (!REPEAT_EN) begin
      state_d = IDLE;
      hold_d  = '0;
      rpt_d   = press_evt;
    end else begin
      case (state_q)
        IDLE: begin
          hold_d = '0;
          if (press_evt) begin
            state_d = DELAY;
            rpt_d   = 1'b1;
          end
        end
        DELAY: begin
          if (release_evt) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_q == DELAY_LAST) begin
            state_d = RPT;
            hold_d  = '0;
            rpt_d   = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        RPT: begin
          if (release_evt) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_q == PERIOD_LAST) begin
            hold_d = '0;
            rpt_d  = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

module btn_conditioner #(
  parameter int               N_BTN         = 4,
  parameter int               ACTIVE_LOW    = 1,
  parameter int               DB_CYCLES     = 500000,
  parameter int               REPEAT_DELAY  = 25000000,
  parameter int               REPEAT_PERIOD = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 4'b1100
) (
  input  logic                 MCLK,
  input  logic                 RST,
  input  logic [N_BTN-1:0]     BT,
  output logic [N_BTN-1:0]     BT_LEVEL,
  output logic [N_BTN-1:0]     BT_PRESS,
  output logic [N_BTN-1:0]     BT_RELEASE,
  output logic [N_BTN-1:0]     BT_REPEAT,
  output logic [2*N_BTN-1:0]   dbg_state
);

  // dbg_state packs each channel's repeat state (0 idle, 1 delay, 2 repeating), channel 0 lowest.
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0] ch_state;

    btn_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_ch (
      .clk  (MCLK),
      .rst  (RST),
      .raw  (BT[i]),
      .level(BT_LEVEL[i]),
      .press(BT_PRESS[i]),
      .rls  (BT_RELEASE[i]),
      .rpt  (BT_REPEAT[i]),
      .state(ch_state)
    );

    assign dbg_state[2*i +: 2] = ch_state;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulse events are queued as stimulus is driven
// and matched against every pulse the DUT emits; levels and states are spot-checked.

module tb_btn_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int W  = 32;
  localparam int LAT = DB + 2;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_RPT   = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   bt;
  logic [N-1:0]   lvl;
  logic [N-1:0]   prs;
  logic [N-1:0]   rls;
  logic [N-1:0]   rpt;
  logic [2*N-1:0] dbg;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  btn_conditioner #(
    .N_BTN        (N),
    .ACTIVE_LOW   (1),
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK  (4'b1100)
  ) dut (
    .MCLK      (clk),
    .RST       (rst),
    .BT        (bt),
    .BT_LEVEL  (lvl),
    .BT_PRESS  (prs),
    .BT_RELEASE(rls),
    .BT_REPEAT (rpt),
    .dbg_state (dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] make_ev(input int c, input int k, input int ch);
    return {c[27:0], k[1:0], ch[1:0]};
  endfunction

  task automatic expect_ev(input int c, input int k, input int ch);
    exp_q.push_back(make_ev(c, k, ch));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [N-1:0] v;
    logic [W-1:0] got;
    logic [W-1:0] exp_ev;
    for (int k = 0; k < 3; k++) begin
      v = (k == K_PRESS) ? prs : (k == K_REL) ? rls : rpt;
      for (int ch = 0; ch < N; ch++) begin
        if (v[ch] === 1'b1) begin
          got = make_ev(cyc, k, ch);
          exp_ev = (exp_q.size() == 0) ? '1 : exp_q.pop_front();
          n_checks++;
          assert (got === exp_ev)
          else begin
            n_errors++;
            $error("FAIL pulse_event observed cyc=%0d kind=%0d ch=%0d expected cyc=%0d kind=%0d ch=%0d",
                   got[31:4], got[3:2], got[1:0], exp_ev[31:4], exp_ev[3:2], exp_ev[1:0]);
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    int p;
    int f;

    rst = 1'b1;
    bt  = '1;
    step(3);
    check("reset_outputs", {lvl, prs, rls, rpt}, '0);
    check("reset_state", dbg, '0);
    rst = 1'b0;
    step(8);
    check("idle_level", lvl, '0);

    // Clean press and release on channel 0 (no auto-repeat on this channel).
    c = cyc;
    bt[0] = 1'b0;
    expect_ev(c + LAT, K_PRESS, 0);
    expect_ev(c + LAT, K_RPT, 0);
    step(LAT - 1);
    check("s1_level_not_early", lvl[0], 1'b0);
    step(1);
    check("s1_level_high", lvl[0], 1'b1);
    check("s1_press_vec", prs, 4'b0001);
    step(30 - LAT);
    c = cyc;
    bt[0] = 1'b1;
    expect_ev(c + LAT, K_REL, 0);
    step(LAT - 1);
    check("s1_level_still_high", lvl[0], 1'b1);
    step(1);
    check("s1_level_low", lvl[0], 1'b0);
    check("s1_release_vec", rls, 4'b0001);
    step(4);
    check("s1_drain", exp_q.size(), 0);

    // Glitch of DB-1 cycles on channel 1 must be rejected.
    bt[1] = 1'b0;
    step(DB - 1);
    bt[1] = 1'b1;
    step(10);
    check("s2_glitch_level", lvl[1], 1'b0);
    check("s2_drain", exp_q.size(), 0);

    // Auto-repeat on channel 2, held 40 cycles; the repeat due on the release edge is dropped.
    c = cyc;
    bt[2] = 1'b0;
    p = c + LAT;
    expect_ev(p, K_PRESS, 2);
    expect_ev(p, K_RPT, 2);
    for (int m = 0; m < 10; m++) expect_ev(p + RD + RP * m, K_RPT, 2);
    expect_ev(p + 40, K_REL, 2);
    step(LAT + 2);
    check("s3_state_delay", dbg[5:4], 2'd1);
    step(RD);
    check("s3_state_rpt", dbg[5:4], 2'd2);
    step(40 - (LAT + 2 + RD));
    bt[2] = 1'b1;
    step(LAT + 8);
    check("s3_state_idle", dbg[5:4], 2'd0);
    check("s3_drain", exp_q.size(), 0);

    // Bouncy press on channel 3: one press, timed from the final transition.
    bt[3] = 1'b0;
    step(1);
    bt[3] = 1'b1;
    step(1);
    bt[3] = 1'b0;
    step(1);
    bt[3] = 1'b1;
    step(1);
    bt[3] = 1'b0;
    f = cyc;
    expect_ev(f + LAT, K_PRESS, 3);
    expect_ev(f + LAT, K_RPT, 3);
    step(LAT);
    check("s4_press_bit", prs[3], 1'b1);
    step(2);
    c = cyc;
    bt[3] = 1'b1;
    expect_ev(c + LAT, K_REL, 3);
    step(10);
    check("s4_drain", exp_q.size(), 0);

    // Reset while channel 2 is held: progress discarded, treated as a fresh press afterwards.
    c = cyc;
    bt[2] = 1'b0;
    p = c + LAT;
    expect_ev(p, K_PRESS, 2);
    expect_ev(p, K_RPT, 2);
    expect_ev(p + 5 + LAT, K_PRESS, 2);
    expect_ev(p + 5 + LAT, K_RPT, 2);
    for (int m = 0; m < 5; m++) expect_ev(p + 5 + LAT + RD + RP * m, K_RPT, 2);
    expect_ev(p + 28 + LAT, K_REL, 2);
    step(LAT + 4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("s5_reset_outputs", {lvl, prs, rls, rpt}, '0);
    check("s5_reset_state", dbg, '0);
    step(LAT);
    check("s5_repress_level", lvl[2], 1'b1);
    step(28 - 5 - LAT);
    bt[2] = 1'b1;
    step(12);
    check("s5_drain", exp_q.size(), 0);

    // Simultaneous presses on channels 0 and 3.
    c = cyc;
    bt[0] = 1'b0;
    bt[3] = 1'b0;
    expect_ev(c + LAT, K_PRESS, 0);
    expect_ev(c + LAT, K_PRESS, 3);
    expect_ev(c + LAT, K_RPT, 0);
    expect_ev(c + LAT, K_RPT, 3);
    expect_ev(c + 10 + LAT, K_REL, 0);
    expect_ev(c + 10 + LAT, K_REL, 3);
    step(LAT);
    check("s6_press_vec", prs, 4'b1001);
    check("s6_repeat_vec", rpt, 4'b1001);
    step(10 - LAT);
    bt[0] = 1'b1;
    bt[3] = 1'b1;
    step(10);
    check("s6_level_final", lvl, '0);
    check("s6_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
